// File: rtl/snax_alu_job_sched.sv
// Job scheduler for the SNAX ALU: buffers core-side job configs in a FIFO and
// issues them one at a time to the accelerator, tracking busy and completions.
module snax_alu_job_sched #(
  parameter int unsigned RegRWCount   = 3,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned JobDepth     = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [RegRWCount*RegDataWidth-1:0] job_cfg_i,
  input  logic                               job_valid_i,
  output logic                               job_ready_o,
  input  logic                               flush_i,
  output logic [RegRWCount*RegDataWidth-1:0] acc_cfg_o,
  output logic                               acc_cfg_valid_o,
  input  logic                               acc_cfg_ready_i,
  input  logic                               acc_busy_i,
  output logic [$clog2(JobDepth):0]          pending_o,
  output logic [RegDataWidth-1:0]            done_count_o,
  output logic                               idle_o
);

  localparam int unsigned CfgW = RegRWCount * RegDataWidth;
  localparam int unsigned PtrW = $clog2(JobDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_e;

  state_e                  state_q;
  logic [CfgW-1:0]         mem_q [JobDepth];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         cnt_q;
  logic [RegDataWidth-1:0] done_q;

  logic [CfgW-1:0]         head;
  logic [RegDataWidth-1:0] head_len;
  logic                    empty, full, push, pop, issue_pop, drop, head_issuable;

  assign head          = mem_q[rd_ptr_q];
  assign head_len      = head[2*RegDataWidth-1:RegDataWidth];
  assign empty         = (cnt_q == '0);
  assign full          = (cnt_q == CntW'(JobDepth));
  assign job_ready_o   = !full && !flush_i;
  assign push          = job_valid_i && job_ready_o;
  assign issue_pop     = (state_q == ISSUE) && acc_cfg_ready_i;
  assign drop          = (state_q == IDLE) && !flush_i && !empty && (head_len == '0);
  assign pop           = issue_pop || drop;
  assign head_issuable = !flush_i && !empty && (head_len != '0);

  assign pending_o    = cnt_q;
  assign done_count_o = done_q;
  assign idle_o       = (state_q == IDLE) && empty;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= job_cfg_i;
  end

  // Flush during ISSUE keeps only the head so the pending handshake stays valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      if (state_q == ISSUE) begin
        wr_ptr_q <= rd_ptr_q + 1'b1;
        rd_ptr_q <= rd_ptr_q + PtrW'(issue_pop);
        cnt_q    <= issue_pop ? '0 : CntW'(1);
      end else begin
        wr_ptr_q <= rd_ptr_q;
        cnt_q    <= '0;
      end
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      acc_cfg_valid_o <= 1'b0;
      acc_cfg_o       <= '0;
      done_q          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (head_issuable) begin
            state_q         <= ISSUE;
            acc_cfg_valid_o <= 1'b1;
            acc_cfg_o       <= head;
          end else if (drop) begin
            done_q <= done_q + 1'b1;
          end
        end
        ISSUE: begin
          if (acc_cfg_ready_i) begin
            state_q         <= WAIT_START;
            acc_cfg_valid_o <= 1'b0;
            acc_cfg_o       <= '0;
          end
        end
        WAIT_START: begin
          if (acc_busy_i) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!acc_busy_i) begin
            done_q <= done_q + 1'b1;
            if (head_issuable) begin
              state_q         <= ISSUE;
              acc_cfg_valid_o <= 1'b1;
              acc_cfg_o       <= head;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snax_alu_job_sched.sv
// Scoreboard bench for snax_alu_job_sched: accepted jobs queue up as expected
// issues; a monitor compares every config handshake and output invariants.
module tb_snax_alu_job_sched;
  localparam int unsigned RegRWCount = 3;
  localparam int unsigned RDW        = 32;
  localparam int unsigned JobDepth   = 4;
  localparam int unsigned CfgW       = RegRWCount * RDW;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [CfgW-1:0]   job_cfg_i;
  logic              job_valid_i;
  logic              job_ready_o;
  logic              flush_i;
  logic [CfgW-1:0]   acc_cfg_o;
  logic              acc_cfg_valid_o;
  logic              acc_cfg_ready_i;
  logic              acc_busy_i;
  logic [$clog2(JobDepth):0] pending_o;
  logic [RDW-1:0]    done_count_o;
  logic              idle_o;

  snax_alu_job_sched #(
    .RegRWCount  (RegRWCount),
    .RegDataWidth(RDW),
    .JobDepth    (JobDepth)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .job_cfg_i      (job_cfg_i),
    .job_valid_i    (job_valid_i),
    .job_ready_o    (job_ready_o),
    .flush_i        (flush_i),
    .acc_cfg_o      (acc_cfg_o),
    .acc_cfg_valid_o(acc_cfg_valid_o),
    .acc_cfg_ready_i(acc_cfg_ready_i),
    .acc_busy_i     (acc_busy_i),
    .pending_o      (pending_o),
    .done_count_o   (done_count_o),
    .idle_o         (idle_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned     n_checks = 0;
  int unsigned     n_pass   = 0;
  logic [CfgW-1:0] q[$];           // accepted, not yet issued/dropped jobs
  logic [RDW-1:0]  exp_done = '0;  // accepted jobs minus flushed ones
  logic            hs_seen  = 1'b0;
  int unsigned     hs_len   = 0;
  int unsigned     rem      = 0;
  logic            ready_low = 1'b0;
  logic            rand_rdy  = 1'b0;
  logic            saw_full  = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [CfgW-1:0] mk(input logic [1:0] op, input logic [31:0] len,
                                         input logic [31:0] spare);
    return {spare, len, 30'b0, op};
  endfunction

  // Accelerator model: busy rises the cycle after handshake, held for len cycles.
  initial begin
    acc_busy_i      = 1'b0;
    acc_cfg_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_ni) begin
        acc_busy_i = 1'b0;
        rem        = 0;
        hs_seen    = 1'b0;
      end else if (hs_seen) begin
        hs_seen    = 1'b0;
        acc_busy_i = 1'b1;
        rem        = hs_len;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) acc_busy_i = 1'b0;
      end
      acc_cfg_ready_i = ready_low ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor / scoreboard
  initial begin
    logic            prev_v, prev_hs, hs;
    logic [CfgW-1:0] prev_cfg, exp, front;
    prev_v = 1'b0; prev_hs = 1'b0; prev_cfg = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && !prev_hs) begin
          check("valid_held", acc_cfg_valid_o, 1'b1);
          check("data_stable", acc_cfg_o, prev_cfg);
        end
        if (!acc_cfg_valid_o) check("cfg_zero_when_invalid", acc_cfg_o, '0);
        hs = acc_cfg_valid_o && acc_cfg_ready_i;
        if (hs) begin
          while (q.size() > 0) begin
            front = q[0];
            if (front[63:32] != 0) break;
            void'(q.pop_front());
          end
          check("issue_expected", q.size() != 0, 1'b1);
          if (q.size() != 0) begin
            exp = q.pop_front();
            check("issue_cfg", acc_cfg_o, exp);
          end
          hs_seen = 1'b1;
          hs_len  = acc_cfg_o[63:32];
        end
        prev_v = acc_cfg_valid_o; prev_hs = hs; prev_cfg = acc_cfg_o;
      end
    end
  end

  task automatic push_job(input logic [CfgW-1:0] cfg);
    logic accepted = 1'b0;
    job_cfg_i   = cfg;
    job_valid_i = 1'b1;
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge clk_i);
      if (job_ready_o) begin
        accepted = 1'b1;
        q.push_back(cfg);
        exp_done++;
      end else if (!flush_i) begin
        check("full_pending", pending_o, JobDepth);
        saw_full = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end
    job_valid_i = 1'b0;
    job_cfg_i   = '0;
    check("push_accepted", accepted, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    logic            ok = 1'b0;
    logic [CfgW-1:0] front;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk_i);
      if (idle_o && !acc_busy_i && rem == 0) ok = 1'b1;
    end
    check({name, "_idle"}, ok, 1'b1);
    check({name, "_done_count"}, done_count_o, exp_done);
    while (q.size() > 0) begin
      front = q[0];
      if (front[63:32] != 0) break;
      void'(q.pop_front());
    end
    check({name, "_all_issued"}, q.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic found;
    int unsigned nflushed;
    rst_ni = 1'b0; job_valid_i = 1'b0; flush_i = 1'b0; job_cfg_i = '0;
    #3;
    check("rst_job_ready", job_ready_o, 1'b1);
    check("rst_valid", acc_cfg_valid_o, 1'b0);
    check("rst_cfg", acc_cfg_o, '0);
    check("rst_pending", pending_o, 0);
    check("rst_done", done_count_o, 0);
    check("rst_idle", idle_o, 1'b1);
    @(posedge clk_i); #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // 1: single job latency
    push_job(mk(2'd1, 32'd4, 32'd0));
    @(negedge clk_i); check("t1_valid_n1", acc_cfg_valid_o, 1'b0);
    @(negedge clk_i); check("t1_valid_n2", acc_cfg_valid_o, 1'b1);
    wait_idle("t1");

    // 2: fill the FIFO while a long job runs
    saw_full = 1'b0;
    push_job(mk(2'd2, 32'd8, 32'hA5A5_0001));
    for (int i = 0; i < 5; i++) push_job(mk(2'($urandom_range(0, 3)), 32'd3, $urandom));
    check("t2_saw_full", saw_full, 1'b1);
    wait_idle("t2");

    // 3: hold ready low while valid
    ready_low = 1'b1;
    push_job(mk(2'd3, 32'd2, 32'hDEAD_BEEF));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      if (acc_cfg_valid_o) found = 1'b1;
    end
    check("t3_valid_seen", found, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("t3_valid_hold", acc_cfg_valid_o, 1'b1);
      check("t3_pending_hold", pending_o, 1);
    end
    ready_low = 1'b0;
    wait_idle("t3");

    // 4: zero-length job is dropped without issue
    push_job(mk(2'd1, 32'd0, 32'd0));
    @(negedge clk_i);
    check("t4_done_before", done_count_o, exp_done - 1);
    check("t4_no_valid", acc_cfg_valid_o, 1'b0);
    @(negedge clk_i);
    check("t4_done_after", done_count_o, exp_done);
    check("t4_no_valid2", acc_cfg_valid_o, 1'b0);
    @(posedge clk_i); #1;
    push_job(mk(2'd0, 32'd3, 32'h1234));
    wait_idle("t4");

    // 5: flush with 3 queued and one in flight, plus a refused push
    push_job(mk(2'd1, 32'd12, 32'h55));
    for (int i = 0; i < 3; i++) push_job(mk(2'd2, 32'd2, $urandom));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      if (acc_busy_i) found = 1'b1;
    end
    check("t5_running", found, 1'b1);
    check("t5_pending3", pending_o, 3);
    flush_i = 1'b1; job_valid_i = 1'b1; job_cfg_i = mk(2'd3, 32'd5, 32'hBAD);
    #1 check("t5_ready_low_on_flush", job_ready_o, 1'b0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; job_valid_i = 1'b0; job_cfg_i = '0;
    nflushed = q.size();
    q.delete();
    exp_done = exp_done - RDW'(nflushed);
    @(negedge clk_i); check("t5_pending0", pending_o, 0);
    wait_idle("t5");

    // 6: done counter wrap
    @(negedge clk_i);
    force dut.done_q = '1;
    #1 release dut.done_q;
    exp_done = '1;
    check("t6_preload", done_count_o, 32'hFFFF_FFFF);
    @(posedge clk_i); #1;
    push_job(mk(2'd1, 32'd2, 32'd7));
    wait_idle("t6");

    // randomized traffic with random ready
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      push_job(mk(2'($urandom_range(0, 3)), 32'($urandom_range(0, 5)), $urandom));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        @(posedge clk_i); #1;
      end
    end
    wait_idle("rand");
    rand_rdy = 1'b0;

    // asynchronous reset mid-job
    push_job(mk(2'd1, 32'd6, 32'd9));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      if (acc_busy_i) found = 1'b1;
    end
    check("rst_mid_running", found, 1'b1);
    @(posedge clk_i); #1;
    push_job(mk(2'd2, 32'd3, 32'd10));
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_valid", acc_cfg_valid_o, 1'b0);
    check("rst_mid_pending", pending_o, 0);
    check("rst_mid_done", done_count_o, 0);
    check("rst_mid_idle", idle_o, 1'b1);
    check("rst_mid_ready", job_ready_o, 1'b1);
    q.delete();
    exp_done = '0;
    @(posedge clk_i); #2 rst_ni = 1'b1;
    wait_idle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
